arm_hps_pio_hps2fpga: RTL
=========================

# arm_hps_pio_hps2fpga

HPS-to-FPGA parallel output port on the lightweight HPS bridge, the write-direction counterpart of the FPGA-to-HPS input PIO. It is an Avalon-MM slave that holds a DATA_WIDTH-bit output register driving fabric logic (e.g. FIR coefficient or control words). Every HPS update is announced to the fabric with a valid/ready handshake, and a sticky overrun flag reports updates the fabric did not consume in time.

## Interface
- DATA_WIDTH, 16, width of out_port (1..32)
- RESET_VALUE, 0, out_port value after reset
- clk  in  1  bridge clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  registered read data, zero-extended
- out_port  out  DATA_WIDTH  output register to fabric
- out_valid  out  1  update pending for fabric
- out_ready  in  1  fabric accepts the pending update

## Operation
- Register map (word addresses):
  - 0 DATA: write loads out_port. Read returns out_port.
  - 1 STATUS: read returns {30'b0, overrun, out_valid}. Writing 1 to bit1 clears overrun. Bit0 is read-only.
  - 2 OUTSET: write gives out_port |= writedata. Read returns 0.
  - 3 OUTCLEAR: write gives out_port &= ~writedata. Read returns 0.
- A launching write is a write (chipselect & ~write_n) to address 0, 2 or 3.
- Handshake FSM, two states:
  - IDLE: out_valid=0. Launching write goes to PEND.
  - PEND: out_valid=1. out_ready=1 with no launching write goes to IDLE. out_ready=1 together with a launching write stays in PEND for the new data; this is not an overrun.
- Overrun: a launching write in PEND while out_ready=0 sets overrun. out_port still updates and the FSM stays in PEND.
- Clear vs set: clearing overrun and setting it need writes to different addresses, so they never collide.
- Read mux: addresses 2 and 3 read as 0.
- Mid-operation reset: reset asserted during PEND or mid-access returns all state to reset values immediately.

## Timing
- Reset values: out_port=RESET_VALUE, out_valid=0, overrun=0, readdata=0, FSM=IDLE.
- Write to out_port: out_port shows the new value on the clock edge after the write cycle. out_valid rises on the same edge.
- Handshake completes on the edge where out_valid & out_ready. out_valid is low the next cycle unless a launching write occurred.
- Reads: readdata is registered every cycle from address (no chipselect gating), so read latency is 1 cycle. A read in the same cycle as a write returns the pre-write value.
- out_ready is ignored in IDLE.
- No wait states. Writes are accepted every cycle.

## Structure
- Shared package: register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_OUTSET=2, ADDR_OUTCLEAR=3; STATUS bit indices ST_VALID=0, ST_OVERRUN=1; FSM state enum {IDLE, PEND}.
- One natural sub-module, arm_hps_pio_handshake. It contains the IDLE/PEND FSM and the overrun flag. Inputs: launch, out_ready, ovr_clr. Outputs: out_valid, overrun.
- The top level holds the register file, the set/clear arithmetic and the read mux.

## Test plan
- Reset: assert reset mid-PEND with out_port=0x1234 -> out_port=RESET_VALUE, out_valid=0, overrun=0, readdata=0 immediately.
- DATA write 0xA5A5, out_ready=0 -> out_port=0xA5A5 and out_valid=1 next edge. Read addr 1 gives 0x1. out_ready pulse -> out_valid=0 the cycle after.
- Set/clear: DATA=0x00F0, OUTSET 0x0F0F -> 0x0FFF. OUTCLEAR 0x00FF -> 0x0F00. Each write raises out_valid. Reads of addr 2/3 return 0.
- Overrun: two DATA writes (0x1, then 0x2) with out_ready=0 -> out_port=0x2, STATUS=0x3. Write STATUS 0x2 -> STATUS=0x1.
- Simultaneous: in PEND, DATA write 0x55 in the same cycle as out_ready=1 -> out_valid stays 1, out_port=0x55, overrun stays 0.
- Width: writedata 0xFFFF_1234 to DATA with DATA_WIDTH=16 -> out_port=0x1234, readdata addr 0 = 0x0000_1234 one cycle after the read.

Source files
------------

// File: rtl/arm_hps_pio_hps2fpga_pkg.sv
// Shared definitions for the HPS-to-FPGA output PIO: register map,
// STATUS bit layout and handshake state encoding.
package arm_hps_pio_hps2fpga_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 2'd3;

  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_OVERRUN = 1;

  // Field order matches ST_OVERRUN/ST_VALID bit positions
  typedef struct packed {
    logic overrun;
    logic valid;
  } status_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_e;

endpackage

// File: rtl/arm_hps_pio_hps2fpga_if.sv
// Avalon-MM slave bus plus fabric-side output handshake of the output PIO.
interface arm_hps_pio_hps2fpga_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  import arm_hps_pio_hps2fpga_pkg::*;

  logic [ADDR_W-1:0]     address;
  logic                  chipselect;
  logic                  write_n;
  logic [BUS_W-1:0]      writedata;
  logic [BUS_W-1:0]      readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid
  );

endinterface

// File: rtl/arm_hps_pio_handshake.sv
// IDLE/PEND update handshake toward the fabric with a sticky overrun flag
// set when a new update lands before the previous one was accepted.
module arm_hps_pio_handshake
  import arm_hps_pio_hps2fpga_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic out_ready,
  input  logic ovr_clr,
  output logic out_valid,
  output logic overrun
);

  hs_state_e state_q, state_d;
  logic      ovr_set_c;
  logic      overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A launch in PEND keeps the FSM pending; it only overruns if unaccepted
  always_comb begin
    state_d   = state_q;
    ovr_set_c = 1'b0;
    case (state_q)
      IDLE: if (launch) state_d = PEND;
      PEND: begin
        if (launch)         ovr_set_c = ~out_ready;
        else if (out_ready) state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overrun_q <= 1'b0;
    else if (ovr_set_c) overrun_q <= 1'b1;
    else if (ovr_clr)   overrun_q <= 1'b0;
  end

  assign out_valid = (state_q == PEND);
  assign overrun   = overrun_q;

endmodule

// File: rtl/arm_hps_pio_hps2fpga.sv
// HPS-to-FPGA output PIO: Avalon-MM register file with DATA/SET/CLEAR
// update modes, STATUS readback and a valid/ready announcement per update.
module arm_hps_pio_hps2fpga
  import arm_hps_pio_hps2fpga_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  arm_hps_pio_hps2fpga_if.slave   bus
);

  logic                  wr_c;
  logic                  launch_c;
  logic                  ovr_clr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] port_q, port_d;
  logic [BUS_W-1:0]      rdata_q, rdata_d;
  status_t               status_c;
  logic                  out_valid;
  logic                  overrun;
  logic                  unused_wdata;

  assign wr_c      = bus.chipselect & ~bus.write_n;
  assign launch_c  = wr_c & (bus.address != ADDR_STATUS);
  assign ovr_clr_c = wr_c & (bus.address == ADDR_STATUS) & bus.writedata[ST_OVERRUN];
  assign wdata_c   = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wdata = &{1'b0, bus.writedata};

  // Output register update: load, bit-set or bit-clear
  always_comb begin
    port_d = port_q;
    if (wr_c) begin
      case (bus.address)
        ADDR_DATA:     port_d = wdata_c;
        ADDR_OUTSET:   port_d = port_q | wdata_c;
        ADDR_OUTCLEAR: port_d = port_q & ~wdata_c;
        default:       port_d = port_q;
      endcase
    end
  end

  // Read mux sees pre-write state; addresses 2/3 read as zero
  always_comb begin
    status_c.overrun = overrun;
    status_c.valid   = out_valid;
    rdata_d          = '0;
    case (bus.address)
      ADDR_DATA:   rdata_d = BUS_W'(port_q);
      ADDR_STATUS: rdata_d = BUS_W'(status_c);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q  <= RESET_VALUE;
      rdata_q <= '0;
    end else begin
      port_q  <= port_d;
      rdata_q <= rdata_d;
    end
  end

  arm_hps_pio_handshake u_handshake (
    .clk       (clk),
    .reset     (reset),
    .launch    (launch_c),
    .out_ready (bus.out_ready),
    .ovr_clr   (ovr_clr_c),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  assign bus.out_port  = port_q;
  assign bus.out_valid = out_valid;
  assign bus.readdata  = rdata_q;

endmodule
